// File: rtl/spmv_pkg.sv
// Shared types and default widths for the SpMV row accumulator.
package spmv_pkg;

    localparam int ROW_W_DEF  = 8;
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } spmv_state_e;

endpackage

// File: rtl/spmv_acc_add.sv
// Accumulator adder: sign-extends the product and adds it to the running sum.
// Define SATURATE_EN to clamp to the signed ACC_W range; otherwise the sum wraps.
module spmv_acc_add
    import spmv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o
);

    logic [ACC_W:0] wide_sum;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign wide_sum = {acc_i[ACC_W-1], acc_i}
                    + {{(ACC_W + 1 - DATA_W){prod_i[DATA_W-1]}}, prod_i};

`ifdef SATURATE_EN
    always_comb begin
        sum_o = wide_sum[ACC_W-1:0];
        if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
            sum_o = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_o = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/spmv_row_accumulator.sv
// Sums consecutive same-row products from two FWFT FIFOs and writes row sums to the
// result memory; flush closes the last row. Overflow mode selected by SATURATE_EN.
module spmv_row_accumulator
    import spmv_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ROW_W-1:0]  row_id_out,
    input  logic              row_id_empty,
    output logic              row_id_rd_en,
    input  logic [DATA_W-1:0] mult_out,
    input  logic              mult_empty,
    output logic              mult_rd_en,
    input  logic              flush,
    output logic [ROW_W-1:0]  wr_addr,
    output logic [ACC_W-1:0]  wr_data,
    output logic              wr_en,
    output logic              done,
    output logic [ROW_W:0]    rows_written
);

    spmv_state_e       state_q, state_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              flush_pending_q, flush_pending_d;
    logic              close_row_q, close_row_d;
    logic              wr_en_q, wr_en_d;
    logic [ROW_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ACC_W-1:0]  wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [ROW_W:0]    rows_q;

    logic              pop;
    logic              fifos_empty;
    logic              same_row;
    logic [ACC_W-1:0]  add_base;
    logic [ACC_W-1:0]  add_sum;

    // Pops are also held off in FLUSH so a late arrival cannot be lost behind done.
    assign pop          = !row_id_empty && !mult_empty
                        && (state_q == IDLE || state_q == ACCUM);
    assign row_id_rd_en = pop;
    assign mult_rd_en   = pop;
    assign fifos_empty  = row_id_empty && mult_empty;
    assign same_row     = (row_id_out == cur_row_q);

    // Starting a new row is just an add onto zero, so one adder serves both cases.
    assign add_base = (state_q == ACCUM && same_row) ? acc_q : '0;

    spmv_acc_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_i  (add_base),
        .prod_i (mult_out),
        .sum_o  (add_sum)
    );

    always_comb begin
        state_d         = state_q;
        cur_row_d       = cur_row_q;
        acc_d           = acc_q;
        flush_pending_d = flush_pending_q || flush;
        close_row_d     = close_row_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_row_d = row_id_out;
                    acc_d     = add_sum;
                    state_d   = ACCUM;
                end else if (flush_pending_q && fifos_empty) begin
                    close_row_d = 1'b0;
                    state_d     = FLUSH;
                end
            end
            ACCUM: begin
                if (pop) begin
                    if (!same_row) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_row_q;
                        wr_data_d = acc_q;
                        cur_row_d = row_id_out;
                    end
                    acc_d = add_sum;
                end else if (flush_pending_q && fifos_empty) begin
                    close_row_d = 1'b1;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                if (close_row_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_row_q;
                    wr_data_d = acc_q;
                end
                state_d = DONE;
            end
            DONE: begin
                done_d          = 1'b1;
                flush_pending_d = flush;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= IDLE;
            cur_row_q       <= '0;
            acc_q           <= '0;
            flush_pending_q <= 1'b0;
            close_row_q     <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            done_q          <= 1'b0;
            rows_q          <= '0;
        end else begin
            state_q         <= state_d;
            cur_row_q       <= cur_row_d;
            acc_q           <= acc_d;
            flush_pending_q <= flush_pending_d;
            close_row_q     <= close_row_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            done_q          <= done_d;
            // Counted from the next-state strobe so the count moves with wr_en.
            if (wr_en_d && !(&rows_q)) begin
                rows_q <= rows_q + 1'b1;
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign done         = done_q;
    assign rows_written = rows_q;

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Scoreboard bench for spmv_row_accumulator: FIFO model feeds the DUT, expected writes queued at stimulus time.
module tb_spmv_row_accumulator;

    localparam int ROW_W  = 8;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 24;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [ROW_W-1:0]  row_id_out;
    logic              row_id_empty;
    logic              row_id_rd_en;
    logic [DATA_W-1:0] mult_out;
    logic              mult_empty;
    logic              mult_rd_en;
    logic              flush;
    logic [ROW_W-1:0]  wr_addr;
    logic [ACC_W-1:0]  wr_data;
    logic              wr_en;
    logic              done;
    logic [ROW_W:0]    rows_written;

    logic              row_id_rd_en_16, mult_rd_en_16, wr_en_16, done_16;
    logic [ROW_W-1:0]  wr_addr_16;
    logic [15:0]       wr_data_16;
    logic [ROW_W:0]    rows_written_16;

    always #5 Clk = ~Clk;

    spmv_row_accumulator #(.ROW_W(ROW_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .row_id_out(row_id_out), .row_id_empty(row_id_empty), .row_id_rd_en(row_id_rd_en),
        .mult_out(mult_out), .mult_empty(mult_empty), .mult_rd_en(mult_rd_en),
        .flush(flush), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .done(done), .rows_written(rows_written)
    );

    spmv_row_accumulator #(.ROW_W(ROW_W), .DATA_W(16), .ACC_W(16)) u_dut16 (
        .Clk(Clk), .Reset(Reset),
        .row_id_out(row_id_out), .row_id_empty(row_id_empty), .row_id_rd_en(row_id_rd_en_16),
        .mult_out(mult_out), .mult_empty(mult_empty), .mult_rd_en(mult_rd_en_16),
        .flush(flush), .wr_addr(wr_addr_16), .wr_data(wr_data_16), .wr_en(wr_en_16),
        .done(done_16), .rows_written(rows_written_16)
    );

    int checks = 0;
    int failures = 0;

    logic [ROW_W-1:0]  rq[$];
    logic [DATA_W-1:0] mq[$];
    logic [ROW_W-1:0]  exp_addr_q[$];
    logic [ACC_W-1:0]  exp_data_q[$];
    int                exp_rows;

    bit                m_open;
    logic [ROW_W-1:0]  m_row;
    logic [ACC_W-1:0]  m_acc;

    int cycle, n_pops, first_pop, last_pop, first_wr, last_wr, done_cnt, done_cyc, w16_cnt;
    logic [15:0] w16_data;
    bit pop_now;

    task automatic push_exp(input logic [ROW_W-1:0] a, input logic [ACC_W-1:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        exp_rows++;
    endtask

    task automatic model_pair(input logic [ROW_W-1:0] row, input logic [DATA_W-1:0] val);
        logic [ACC_W-1:0] ext;
        ext = {{(ACC_W-DATA_W){val[DATA_W-1]}}, val};
        if (m_open && row == m_row) begin
            m_acc = m_acc + ext;
        end else begin
            if (m_open) push_exp(m_row, m_acc);
            m_open = 1'b1;
            m_row  = row;
            m_acc  = ext;
        end
    endtask

    task automatic model_flush();
        if (m_open) push_exp(m_row, m_acc);
        m_open = 1'b0;
    endtask

    task automatic push_pair(input logic [ROW_W-1:0] row, input logic [DATA_W-1:0] val);
        rq.push_back(row);
        mq.push_back(val);
        model_pair(row, val);
    endtask

    task automatic clear_run();
        cycle = 0; n_pops = 0; first_pop = -1; last_pop = -1;
        first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1; w16_cnt = 0;
    endtask

    // One clock: present FIFO heads, sample pop before the edge, monitor outputs after it.
    task automatic step();
        row_id_empty = (rq.size() == 0);
        mult_empty   = (mq.size() == 0);
        row_id_out   = (rq.size() > 0) ? rq[0] : '0;
        mult_out     = (mq.size() > 0) ? mq[0] : '0;
        #1;
        pop_now = row_id_rd_en;
        checks++;
        if (row_id_rd_en !== mult_rd_en || (row_id_rd_en && (row_id_empty || mult_empty))) begin
            failures++;
            $display("FAIL rd_en cycle=%0d row_rd=%b mult_rd=%b required pop only when both non-empty, together",
                     cycle, row_id_rd_en, mult_rd_en);
        end
        @(posedge Clk);
        if (pop_now) begin
            void'(rq.pop_front());
            void'(mq.pop_front());
            n_pops++;
        end
        #1;
        cycle++;
        if (pop_now) begin
            if (first_pop < 0) first_pop = cycle;
            last_pop = cycle;
        end
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cycle=%0d got addr=%0d data=%0d required no write",
                         cycle, wr_addr, $signed(wr_data));
            end else begin
                logic [ROW_W-1:0] ea;
                logic [ACC_W-1:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (wr_addr !== ea || wr_data !== ed) begin
                    failures++;
                    $display("FAIL write cycle=%0d got addr=%0d data=%0d required addr=%0d data=%0d",
                             cycle, wr_addr, $signed(wr_data), ea, $signed(ed));
                end else begin
                    $display("write cycle=%0d addr=%0d data=%0d", cycle, wr_addr, $signed(wr_data));
                end
            end
            if (first_wr < 0) first_wr = cycle;
            last_wr = cycle;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cycle;
        end
        if (wr_en_16 === 1'b1) begin
            w16_cnt++;
            w16_data = wr_data_16;
        end
    endtask

    // Pulse flush at step flush_at, run until done (bounded), then verify the stream closed cleanly.
    task automatic run_flush(input string name, input int flush_at, input int budget);
        for (int i = 0; i < budget; i++) begin
            flush = (i == flush_at);
            step();
            flush = 1'b0;
            if (done_cnt > 0) break;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s_timeout got no done within %0d cycles required done pulse", name, budget);
        end
        step();
        step();
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_width got %0d done cycles required 1", name, done_cnt);
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got %0d outstanding required 0", name, exp_addr_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        checks++;
        if (rows_written !== exp_rows[ROW_W:0]) begin
            failures++;
            $display("FAIL %s_rows_written got %0d required %0d", name, rows_written, exp_rows);
        end
        $display("%s: done at cycle %0d, last write %0d, pops %0d, rows_written %0d",
                 name, done_cyc, last_wr, n_pops, rows_written);
    endtask

    task automatic test_reset();
        Reset = 1'b1; flush = 1'b0;
        row_id_empty = 1'b1; mult_empty = 1'b1; row_id_out = '0; mult_out = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got wr_en=%b done=%b required 0 0", wr_en, done);
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0 || rows_written !== '0) begin
            failures++;
            $display("FAIL reset_values got addr=%0d data=%0d rows=%0d required 0 0 0",
                     wr_addr, wr_data, rows_written);
        end
        clear_run();
        repeat (2) step();
        checks++;
        if (n_pops != 0 || first_wr != -1) begin
            failures++;
            $display("FAIL reset_idle got pops=%0d first_wr=%0d required 0 -1", n_pops, first_wr);
        end
        $display("reset: outputs cleared, idle with empty FIFOs");
    endtask

    task automatic test_single_row();
        clear_run();
        for (int i = 0; i < 7; i++) push_pair(8'd1, 16'd1);
        model_flush();
        run_flush("single_row", 7, 60);
        checks++;
        if (done_cyc != last_wr + 1) begin
            failures++;
            $display("FAIL single_row_done_latency got done=%0d write=%0d required done=write+1", done_cyc, last_wr);
        end
        checks++;
        if (n_pops != 7 || last_pop - first_pop != 6) begin
            failures++;
            $display("FAIL single_row_pops got %0d over %0d..%0d required 7 consecutive", n_pops, first_pop, last_pop);
        end
    endtask

    task automatic test_row_change();
        clear_run();
        push_pair(8'd2, 16'd5);
        push_pair(8'd2, 16'hFFFD);
        push_pair(8'd4, 16'd10);
        model_flush();
        run_flush("row_change", 3, 60);
        checks++;
        if (n_pops != 3 || last_pop - first_pop != 2) begin
            failures++;
            $display("FAIL row_change_stall got pops=%0d span=%0d required 3 span 2", n_pops, last_pop - first_pop);
        end
        checks++;
        if (first_wr != last_pop) begin
            failures++;
            $display("FAIL row_change_latency got first write cycle %0d required %0d", first_wr, last_pop);
        end
    endtask

    task automatic test_starvation();
        clear_run();
        rq.push_back(8'd3);
        model_pair(8'd3, 16'd4);
        repeat (5) step();
        checks++;
        if (n_pops != 0 || first_wr != -1) begin
            failures++;
            $display("FAIL starvation_hold got pops=%0d first_wr=%0d required 0 -1", n_pops, first_wr);
        end
        mq.push_back(16'd4);
        step();
        checks++;
        if (n_pops != 1) begin
            failures++;
            $display("FAIL starvation_resume got pops=%0d required 1", n_pops);
        end
        model_flush();
        run_flush("starvation", 0, 60);
    endtask

    task automatic test_overflow();
        logic [15:0] exp16;
`ifdef SATURATE_EN
        exp16 = 16'h7FFF;
`else
        exp16 = 16'h8000;
`endif
        clear_run();
        push_pair(8'd0, 16'd32767);
        push_pair(8'd0, 16'd1);
        model_flush();
        run_flush("overflow", 2, 60);
        checks++;
        if (w16_cnt != 1 || w16_data !== exp16) begin
            failures++;
            $display("FAIL overflow_acc16 got writes=%0d data=%0d required 1 write data=%0d",
                     w16_cnt, $signed(w16_data), $signed(exp16));
        end
    endtask

    task automatic test_reset_mid_row();
        clear_run();
        push_pair(8'd5, 16'd9);
        push_pair(8'd5, 16'd9);
        repeat (3) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        m_open   = 1'b0;
        exp_rows = 0;
        run_flush("reset_mid_row", 0, 60);
        checks++;
        if (first_wr != -1) begin
            failures++;
            $display("FAIL reset_mid_row_write got write at cycle %0d required none", first_wr);
        end
    endtask

    task automatic test_early_flush();
        clear_run();
        for (int i = 0; i < 3; i++) push_pair(8'd6, 16'd2);
        model_flush();
        run_flush("early_flush", 0, 60);
        checks++;
        if (n_pops != 3 || last_wr <= last_pop || done_cyc != last_wr + 1) begin
            failures++;
            $display("FAIL early_flush_order got pops=%0d last_pop=%0d wr=%0d done=%0d required 3 pops, write after drain, done=write+1",
                     n_pops, last_pop, last_wr, done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_run();
        push_pair(8'd7, 16'd1);
        push_pair(8'd8, 16'd2);
        push_pair(8'd7, 16'd3);
        push_pair(8'd7, 16'hFFF0);
        model_flush();
        run_flush("back_to_back", 4, 60);
        checks++;
        if (n_pops != 4 || last_pop - first_pop != 3) begin
            failures++;
            $display("FAIL back_to_back_pops got pops=%0d span=%0d required 4 span 3", n_pops, last_pop - first_pop);
        end
    endtask

    initial begin
        exp_rows = 0;
        m_open   = 1'b0;
        m_row    = '0;
        m_acc    = '0;
        w16_data = '0;
        test_reset();
        test_single_row();
        test_row_change();
        test_starvation();
        test_overflow();
        test_back_to_back();
        test_reset_mid_row();
        test_early_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
